// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants and state encoding for the serial CRC blocks
// Contents:
//   DATA_W  - data bits per codeword
//   CRC_W   - CRC bits per codeword
//   FRAME_W - total serial bits per codeword
//   POLY    - generator polynomial x^8+x^4+x^3+x^2+1 without the implicit x^8 term
//   state_t - receive FSM states
package crc_pkg;

  localparam int DATA_W  = 12;
  localparam int CRC_W   = 8;
  localparam int FRAME_W = DATA_W + CRC_W;

  localparam logic [CRC_W-1:0] POLY = 8'h1D;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational one-bit CRC remainder update
// Ports:
//   r      in  W   current remainder
//   bit_in in  1   next message bit (MSB-first order)
//   r_next out W   remainder after absorbing bit_in
// Shifts bit_in into the remainder and subtracts the polynomial whenever the
// bit shifted out of the top is set, i.e. one step of long division by P.
module crc_step
  import crc_pkg::*;
#(
  parameter int               W = CRC_W,
  parameter logic [W-1:0]     P = POLY
) (
  input  logic [W-1:0] r,
  input  logic         bit_in,
  output logic [W-1:0] r_next
);

  assign r_next = {r[W-2:0], bit_in} ^ (r[W-1] ? P : '0);

endmodule

// File: rtl/crc_check.sv
// rtl/crc_check.sv - serial CRC-8 checker for 12-bit data codewords
// Ports:
//   clk       in  1       rising-edge clock
//   reset     in  1       synchronous, active-high
//   start     in  1       begins (or restarts) a frame
//   bit_in    in  1       serial codeword bit, data MSB first then CRC MSB first
//   bit_valid in  1       bit_in is valid this cycle
//   busy      out 1       frame in progress
//   done      out 1       one-cycle pulse, results below are fresh
//   crc_ok    out 1       final remainder was zero
//   data_out  out DATA_W  recovered data word
//   syndrome  out CRC_W   final remainder
module crc_check
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic              done,
  output logic              crc_ok,
  output logic [DATA_W-1:0] data_out,
  output logic [CRC_W-1:0]  syndrome
);

  localparam logic [4:0] LAST_BIT  = 5'(FRAME_W - 1);
  localparam logic [4:0] DATA_BITS = 5'(DATA_W);

  state_t              state, state_d;
  logic [4:0]          cnt, cnt_d;
  logic [CRC_W-1:0]    rem, rem_d, rem_next;
  logic [DATA_W-1:0]   data_sr, data_d;
  logic                finish;

  crc_step #(.W(CRC_W), .P(POLY)) u_step (
    .r      (rem),
    .bit_in (bit_in),
    .r_next (rem_next)
  );

  assign busy = (state == RECV);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rem_d   = rem;
    data_d  = data_sr;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        // bit_valid is deliberately ignored here, even alongside start
        if (start) begin
          state_d = RECV;
          cnt_d   = '0;
          rem_d   = '0;
          data_d  = '0;
        end
      end
      RECV: begin
        if (start) begin
          // abort and restart; this cycle's bit is dropped
          cnt_d  = '0;
          rem_d  = '0;
          data_d = '0;
        end else if (bit_valid) begin
          rem_d = rem_next;
          cnt_d = cnt + 5'd1;
          if (cnt < DATA_BITS) begin
            data_d = {data_sr[DATA_W-2:0], bit_in};
          end
          if (cnt == LAST_BIT) begin
            state_d = IDLE;
            cnt_d   = '0;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      data_sr  <= '0;
      done     <= 1'b0;
      crc_ok   <= 1'b0;
      data_out <= '0;
      syndrome <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rem     <= rem_d;
      data_sr <= data_d;
      done    <= finish;
      if (finish) begin
        // the data register is complete by now: the last 8 bits are CRC only
        crc_ok   <= (rem_next == '0);
        syndrome <= rem_next;
        data_out <= data_sr;
      end
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// tb/tb_crc_check.sv - self-checking bench for crc_check
module tb_crc_check;
  import crc_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              busy;
  logic              done;
  logic              crc_ok;
  logic [DATA_W-1:0] data_out;
  logic [CRC_W-1:0]  syndrome;

  typedef struct {
    logic [11:0] data;
    logic        ok;
    logic [7:0]  syn;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  crc_check dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .data_out  (data_out),
    .syndrome  (syndrome)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of the 20-bit codeword polynomial modulo x^8+x^4+x^3+x^2+1 by long division
  function automatic logic [7:0] ref_rem(input logic [19:0] cw);
    logic [19:0] v;
    v = cw;
    for (int i = 19; i >= 8; i--) begin
      if (v[i]) v = v ^ (20'h0011D << (i - 8));
    end
    return v[7:0];
  endfunction

  function automatic exp_t expect_of(input logic [19:0] cw);
    exp_t e;
    e.data = cw[19:8];
    e.syn  = ref_rem(cw);
    e.ok   = (e.syn == 8'h00);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start held with bit_valid high: the bit must be ignored
  task automatic start_frame();
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_bits(input logic [19:0] cw, input int first, input int last, input int max_stall);
    for (int i = first; i <= last; i++) begin
      int k;
      k = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      bit_valid = 1'b0;
      bit_in = ~cw[19-i];
      repeat (k) tick();
      bit_in = cw[19-i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
  endtask

  // Full frame; on return we are in the done cycle
  task automatic run_frame(input logic [19:0] cw, input int max_stall, input string tag);
    start_frame();
    sb.push_back(expect_of(cw));
    send_bits(cw, 0, 19, max_stall);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding frame
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_crc_ok", 32'(crc_ok), 32'(e.ok));
        check("sb_data", 32'(data_out), 32'(e.data));
        check("sb_syndrome", 32'(syndrome), 32'(e.syn));
      end
    end
  end

  initial begin
    int d0;

    // reset values
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_crc_ok", 32'(crc_ok), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_syn", 32'(syndrome), 32'd0);

    // bit_valid alone in IDLE does nothing
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (3) tick();
    bit_valid = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);

    // clean vectors
    run_frame({12'h001, 8'h1D}, 0, "clean1");
    check("clean1_ok", 32'(crc_ok), 32'd1);
    check("clean1_data", 32'(data_out), 32'h001);
    check("clean1_syn", 32'(syndrome), 32'h00);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    run_frame({12'h002, 8'h3A}, 0, "clean2");
    check("clean2_ok", 32'(crc_ok), 32'd1);
    tick();
    run_frame({12'h003, 8'h27}, 0, "clean3");
    check("clean3_ok", 32'(crc_ok), 32'd1);
    tick();
    run_frame({12'h000, 8'h00}, 0, "zero");
    check("zero_ok", 32'(crc_ok), 32'd1);
    tick();

    // corrupted CRC and flipped data bit
    run_frame({12'h001, 8'h1C}, 0, "badcrc");
    check("badcrc_ok", 32'(crc_ok), 32'd0);
    check("badcrc_syn", 32'(syndrome), 32'h01);
    check("badcrc_data", 32'(data_out), 32'h001);
    tick();
    run_frame({12'h003, 8'h1D}, 0, "baddata");
    check("baddata_ok", 32'(crc_ok), 32'd0);
    check("baddata_syn", 32'(syndrome), 32'h3A);
    tick();

    // stalls
    run_frame({12'h002, 8'h3A}, 5, "stall");
    check("stall_ok", 32'(crc_ok), 32'd1);
    check("stall_data", 32'(data_out), 32'h002);
    tick();
    check("stall_done_pulse", 32'(done), 32'd0);

    // a few random data words with correct and damaged CRCs
    for (int n = 0; n < 4; n++) begin
      logic [11:0] dw;
      logic [19:0] cw;
      dw = 12'($urandom);
      cw = {dw, 8'h00};
      cw[7:0] = ref_rem(cw);
      if (n[0]) cw[$urandom_range(0, 19)] ^= 1'b1;
      run_frame(cw, 2, "random");
      tick();
    end

    // abort and restart
    d0 = n_done;
    start_frame();
    send_bits({12'hABC, 8'h55}, 0, 6, 0);
    run_frame({12'h003, 8'h27}, 0, "restart");
    check("restart_ok", 32'(crc_ok), 32'd1);
    tick();
    check("restart_one_done", 32'(n_done - d0), 32'd1);

    // reset mid-frame
    d0 = n_done;
    start_frame();
    send_bits({12'hFFF, 8'hFF}, 0, 9, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ok", 32'(crc_ok), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_syn", 32'(syndrome), 32'd0);
    repeat (12) tick();
    check("midrst_no_done", 32'(n_done - d0), 32'd0);

    // back-to-back: restart in the done cycle
    run_frame({12'h001, 8'h1D}, 0, "b2b1");
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(expect_of({12'hC5A, 8'h00}));
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    send_bits({12'hC5A, 8'h00}, 0, 14, 1);
    check("b2b_hold_data", 32'(data_out), 32'h001);
    check("b2b_hold_ok", 32'(crc_ok), 32'd1);
    send_bits({12'hC5A, 8'h00}, 15, 19, 0);
    check("b2b2_done", 32'(done), 32'd1);
    check("b2b2_data", 32'(data_out), 32'hC5A);
    tick();

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
